// File: rtl/river_crossing_ctrl.sv
// river_crossing_ctrl: farmer/cabbage/goat/wolf crossing game controller.
// Holds the bank of every item, accepts one crossing command per cycle in PLAY,
// flags illegal commands, raises alarm on unsafe banks and declares WON/LOST.
// Optional feature macro: UNDO_EN (one-level undo of the last accepted move).
//
// state | meaning
// ------+------------------------------------------------
// PLAY  | game in progress, commands accepted
// WON   | everyone on the far bank, waiting for start
// LOST  | unsafe bank or move budget exhausted
module river_crossing_ctrl #(
  parameter int MOVE_W    = 4,
  parameter int MAX_MOVES = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              move_valid,
  input  logic [1:0]        move_sel,
  input  logic              undo,
  output logic              move_ready,
  output logic [3:0]        pos,
  output logic              alarm,
  output logic              illegal,
  output logic              won,
  output logic              lost,
  output logic [MOVE_W-1:0] move_count
);

  typedef enum logic [1:0] {S_PLAY, S_WON, S_LOST} state_t;

  localparam logic [MOVE_W-1:0] MAX_CNT = MOVE_W'(MAX_MOVES);
  localparam logic [MOVE_W-1:0] CNT_ONE = MOVE_W'(1);

  state_t            state_q, state_d;
  logic [3:0]        pos_q, pos_d;
  logic [MOVE_W-1:0] cnt_q, cnt_d;
  logic              alarm_q, alarm_d;
  logic              illegal_q, illegal_d;

  logic [3:0]        move_mask;
  logic              pass_bank;
  logic              legal;
  logic [3:0]        pos_new;
  logic [MOVE_W-1:0] cnt_new;
  logic              undo_go;

  // pos bits are {F,C,G,W}; unsafe when goat is left with wolf or cabbage
  function automatic logic unsafe(input logic [3:0] p);
    return ((p[1] == p[0]) && (p[3] != p[1])) || ((p[2] == p[1]) && (p[3] != p[1]));
  endfunction

`ifdef UNDO_EN
  logic [3:0]        hist_pos_q, hist_pos_d;
  logic [MOVE_W-1:0] hist_cnt_q, hist_cnt_d;
  logic              hist_vld_q, hist_vld_d;

  assign undo_go = undo && hist_vld_q && (state_q != S_WON);

  // history of the position before the last accepted move
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_pos_q <= 4'b0000;
      hist_cnt_q <= '0;
      hist_vld_q <= 1'b0;
    end else begin
      hist_pos_q <= hist_pos_d;
      hist_cnt_q <= hist_cnt_d;
      hist_vld_q <= hist_vld_d;
    end
  end
`else
  logic unused_undo;
  assign unused_undo = undo;
  assign undo_go     = 1'b0;
`endif

  // decode which bits a crossing toggles and the passenger's current bank
  always_comb begin
    move_mask = 4'b1000;
    pass_bank = pos_q[3];
    case (move_sel)
      2'b01: begin move_mask = 4'b1100; pass_bank = pos_q[2]; end
      2'b10: begin move_mask = 4'b1010; pass_bank = pos_q[1]; end
      2'b11: begin move_mask = 4'b1001; pass_bank = pos_q[0]; end
      default: ;
    endcase
  end

  assign legal   = (pass_bank == pos_q[3]);
  assign pos_new = pos_q ^ move_mask;
  assign cnt_new = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + CNT_ONE;

  // state register and game registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_PLAY;
      pos_q     <= 4'b0000;
      cnt_q     <= '0;
      alarm_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      cnt_q     <= cnt_d;
      alarm_q   <= alarm_d;
      illegal_q <= illegal_d;
    end
  end

  // next-state: start > undo > move_valid
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    cnt_d     = cnt_q;
    alarm_d   = alarm_q;
    illegal_d = 1'b0;
`ifdef UNDO_EN
    hist_pos_d = hist_pos_q;
    hist_cnt_d = hist_cnt_q;
    hist_vld_d = hist_vld_q;
`endif
    if (start) begin
      state_d = S_PLAY;
      pos_d   = 4'b0000;
      cnt_d   = '0;
      alarm_d = 1'b0;
`ifdef UNDO_EN
      hist_vld_d = 1'b0;
`endif
    end else if (undo_go) begin
      state_d = S_PLAY;
      alarm_d = 1'b0;
`ifdef UNDO_EN
      pos_d      = hist_pos_q;
      cnt_d      = hist_cnt_q;
      hist_vld_d = 1'b0;
`endif
    end else if (move_valid && (state_q == S_PLAY)) begin
      if (legal) begin
        pos_d   = pos_new;
        cnt_d   = cnt_new;
        alarm_d = unsafe(pos_new);
`ifdef UNDO_EN
        hist_pos_d = pos_q;
        hist_cnt_d = cnt_q;
        hist_vld_d = 1'b1;
`endif
        if (pos_new == 4'b1111) begin
          state_d = S_WON;
        end else if (unsafe(pos_new) || (cnt_new == MAX_CNT)) begin
          state_d = S_LOST;
        end
      end else begin
        illegal_d = 1'b1;
      end
    end
  end

  assign move_ready = (state_q == S_PLAY);
  assign won        = (state_q == S_WON);
  assign lost       = (state_q == S_LOST);
  assign pos        = pos_q;
  assign alarm      = alarm_q;
  assign illegal    = illegal_q;
  assign move_count = cnt_q;

endmodule

// File: doc/river_crossing_ctrl.md
Name: river_crossing_ctrl

Overview:
Sequential controller for the farmer/cabbage/goat/wolf river-crossing puzzle.
- Holds the bank position of all four items and accepts one crossing command per handshake.
- Rejects illegal crossings, raises the alarm on unsafe bank states and counts moves.
- Declares WON or LOST; sits between the board's switch/button debounce logic and the LED/7-seg display drivers.

Parameters:
MOVE_W, 4, width of move counter
MAX_MOVES, 15, move budget; reaching it without winning loses the game (must be ≤ 2^MOVE_W−1)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  synchronous new-game request
move_valid  input  1  crossing command strobe
move_sel  input  2  passenger: 00 none, 01 cabbage, 10 goat, 11 wolf
undo  input  1  undo request (used only with UNDO_EN)
move_ready  output  1  high when a command is accepted this cycle (state PLAY)
pos  output  4  bank bits {F,C,G,W}; 0 = start bank, 1 = far bank
alarm  output  1  unsafe bank state
illegal  output  1  one-cycle pulse: command rejected
won  output  1  game won
lost  output  1  game lost
move_count  output  MOVE_W  accepted moves this game

Behaviour:
- Reset (async, reset_n=0): state PLAY, pos=0000, move_count=0, alarm=0, illegal=0, won=0, lost=0.
- States:
  - PLAY: move_ready=1.
  - WON: won=1, move_ready=0.
  - LOST: lost=1, move_ready=0.
- Legal move: passenger bank equals F bank (sel 00 always legal).
  - Next edge: F toggles; the passenger bit toggles; move_count increments.
  - One-cycle latency: pos, alarm, won and lost all update on the same edge.
- Illegal move in PLAY: pos and count unchanged; illegal=1 for exactly the next cycle.
- Alarm (registered, from the new pos): alarm = (G==W && F!=G) || (C==G && F!=G).
  - Alarm-true codes: 0011, 0110, 0111, 1000, 1001, 1100.
  - Alarm=1 → next state LOST.
- Win: new pos = 1111 → WON. Win takes priority over the move limit.
- Move limit: legal move making move_count == MAX_MOVES and not a win → LOST.
  - Counter never exceeds MAX_MOVES.
- move_valid outside PLAY: ignored; no illegal pulse.
- start (any state): next edge returns to the reset values. start has priority over move_valid and undo.
- Priority per cycle: reset_n > start > undo (if enabled) > move_valid.
- Reset mid-move: asynchronous reset immediately forces all outputs to their reset values; the in-flight command is discarded.

Optional Feature:
UNDO_EN
- Defined:
  - One-level history register stores pos and move_count before each accepted move.
  - undo=1 in PLAY or LOST with history valid: restore pos/count, state PLAY, alarm=0, lost=0, history invalidated.
  - undo with no valid history, or in WON: ignored.
  - History is invalidated by reset and start.
- Undefined: undo port present but ignored; no history registers synthesised.

Test Plan:
- Optimal solution from reset (MAX_MOVES=15): sel 10,00,11,10,01,00,10 → after 7th move pos=1111, won=1, move_count=7, alarm never high.
- First move sel 01 (cabbage) → pos=1100, alarm=1, lost=1, count=1; further move_valid ignored.
- After sel 10 (pos=1010), sel 01 → illegal=1 for one cycle, pos stays 1010, count stays 1.
- MAX_MOVES=3: sel 10,10,10 → pos=1010, count=3, lost=1, alarm=0.
- UNDO_EN: sel 01 → lost; undo → pos=0000, count=0, PLAY, lost=0, alarm=0; second undo → no change.
- Mid-game (pos=1010), pulse start → pos=0000, count=0; reset_n low mid-cycle → outputs clear without waiting for a clk edge.
